// File: rtl/dsr_frame_lock_chk.sv
// Frame-lock checker behind the DSR bit-slip aligner: settles after each pipe restart,
// qualifies the frame-clock word, holds lock, and requests realignment with a bounded retry budget.
module dsr_frame_lock_chk #(
   parameter int unsigned      FRM_W      = 12,
   parameter logic [FRM_W-1:0] FRM_PAT    = 12'hFC0,
   parameter int unsigned      SETTLE_CYC = 4,
   parameter int unsigned      LOCK_CNT   = 16,
   parameter int unsigned      MISS_LIMIT = 3,
   parameter int unsigned      MAX_RETRY  = 7
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ALIGNED,
   input  logic             STRT_PIPE,
   input  logic [FRM_W-1:0] FRM_DATA,
   output logic             LOCKED,
   output logic             PIPE_EN,
   output logic             REALIGN,
   output logic             ALIGN_FAIL,
   output logic [7:0]       ERR_CNT,
   output logic [3:0]       RETRY_CNT,
   output logic [2:0]       DBG_STATE
);

   // Handshake: STRT_PIPE is a single-cycle strobe, ALIGNED a level, REALIGN a
   // single-cycle strobe back to the aligner; there is no backpressure on any of them.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_CHECK  = 3'd2,
      S_LOCKED = 3'd3,
      S_REQ    = 3'd4,
      S_FAIL   = 3'd5
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
   localparam logic [3:0] MISS_LAST   = 4'(MISS_LIMIT - 1);
   localparam logic [3:0] RETRY_LAST  = 4'(MAX_RETRY - 1);

   state_t     state, state_nxt;
   logic [3:0] settle_cnt, settle_nxt;
   logic [7:0] match_cnt, match_nxt;
   logic [3:0] miss_cnt, miss_nxt;
   logic [7:0] err_cnt, err_nxt;
   logic [3:0] retry_cnt, retry_nxt;
   logic       frm_ok;

   assign frm_ok = (FRM_DATA == FRM_PAT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         settle_cnt <= '0;
         match_cnt  <= '0;
         miss_cnt   <= '0;
         err_cnt    <= '0;
         retry_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         match_cnt  <= match_nxt;
         miss_cnt   <= miss_nxt;
         err_cnt    <= err_nxt;
         retry_cnt  <= retry_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      match_nxt  = match_cnt;
      miss_nxt   = miss_cnt;
      err_nxt    = err_cnt;
      retry_nxt  = retry_cnt;
      // A pipe restart wins over everything else in the active states.
      if (STRT_PIPE && (state == S_IDLE || state == S_SETTLE ||
                        state == S_CHECK || state == S_LOCKED)) begin
         state_nxt  = S_SETTLE;
         settle_nxt = '0;
         err_nxt    = '0;
      end else begin
         case (state)
            S_SETTLE: begin
               if (settle_cnt != 4'hF) settle_nxt = settle_cnt + 4'd1;
               if (settle_cnt == SETTLE_LAST) begin
                  state_nxt = S_CHECK;
                  match_nxt = '0;
               end
            end
            S_CHECK: begin
               if (!ALIGNED) begin
                  state_nxt = S_IDLE;
               end else if (!frm_ok) begin
                  state_nxt = S_REQ;
               end else begin
                  if (match_cnt != 8'hFF) match_nxt = match_cnt + 8'd1;
                  if (match_cnt == LOCK_LAST) begin
                     state_nxt = S_LOCKED;
                     retry_nxt = '0;
                     miss_nxt  = '0;
                  end
               end
            end
            S_LOCKED: begin
               if (!frm_ok) begin
                  if (err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
                  if (miss_cnt != 4'hF) miss_nxt = miss_cnt + 4'd1;
               end else begin
                  miss_nxt = '0;
               end
               if (!ALIGNED) state_nxt = S_IDLE;
               else if (!frm_ok && miss_cnt == MISS_LAST) state_nxt = S_REQ;
            end
            S_REQ: begin
               if (retry_cnt != 4'hF) retry_nxt = retry_cnt + 4'd1;
               state_nxt = (retry_cnt == RETRY_LAST) ? S_FAIL : S_IDLE;
            end
            default: ;
         endcase
      end
   end

   // The request that exhausts the budget goes straight to FAIL without restarting the aligner.
   assign LOCKED     = (state == S_LOCKED);
   assign PIPE_EN    = (state == S_LOCKED);
   assign REALIGN    = (state == S_REQ) && (retry_cnt != RETRY_LAST);
   assign ALIGN_FAIL = (state == S_FAIL);
   assign ERR_CNT    = (state == S_FAIL) ? 8'd0 : err_cnt;
   assign RETRY_CNT  = (state == S_FAIL) ? 4'd0 : retry_cnt;
   assign DBG_STATE  = state;

endmodule

// File: tb/tb_dsr_frame_lock_chk.sv
// Bench for dsr_frame_lock_chk: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a phase/countdown reference model.
module tb_dsr_frame_lock_chk;

   localparam logic [11:0] PAT        = 12'hFC0;
   localparam int          SETTLE_CYC = 4;
   localparam int          LOCK_CNT   = 16;
   localparam int          MISS_LIMIT = 3;
   localparam int          MAX_RETRY  = 7;

   localparam int M_IDLE = 0, M_SETTLE = 1, M_CHECK = 2, M_LOCKED = 3, M_REQ = 4, M_FAIL = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        aligned = 1'b0;
   logic        strt_pipe = 1'b0;
   logic [11:0] frm_data = '0;
   logic        locked, pipe_en, realign, align_fail;
   logic [7:0]  err_cnt;
   logic [3:0]  retry_cnt;
   logic [2:0]  dbg_state;
   logic [15:0] obs;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int rl_double = 0;
   logic rl_prev = 1'b0;

   // reference model
   int m_mode = M_IDLE, m_left = 0, m_run = 0, m_miss = 0, m_err = 0, m_retry = 0;

   dsr_frame_lock_chk dut (
      .CLK(clk), .RST(rst), .ALIGNED(aligned), .STRT_PIPE(strt_pipe), .FRM_DATA(frm_data),
      .LOCKED(locked), .PIPE_EN(pipe_en), .REALIGN(realign), .ALIGN_FAIL(align_fail),
      .ERR_CNT(err_cnt), .RETRY_CNT(retry_cnt), .DBG_STATE(dbg_state)
   );

   assign obs = {locked, pipe_en, realign, align_fail, err_cnt, retry_cnt};

   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic a, input logic s, input logic [11:0] d);
      bit bad;
      bad = (d != PAT);
      if (r) begin
         m_mode = M_IDLE; m_left = 0; m_run = 0; m_miss = 0; m_err = 0; m_retry = 0;
      end else if (s && m_mode <= M_LOCKED) begin
         m_mode = M_SETTLE; m_left = SETTLE_CYC; m_err = 0;
      end else begin
         case (m_mode)
            M_SETTLE: begin
               m_left = m_left - 1;
               if (m_left == 0) begin m_mode = M_CHECK; m_run = 0; end
            end
            M_CHECK: begin
               if (!a) m_mode = M_IDLE;
               else if (bad) m_mode = M_REQ;
               else begin
                  m_run = m_run + 1;
                  if (m_run == LOCK_CNT) begin m_mode = M_LOCKED; m_retry = 0; m_miss = 0; end
               end
            end
            M_LOCKED: begin
               if (bad) begin
                  m_err = (m_err < 255) ? m_err + 1 : 255;
                  m_miss = m_miss + 1;
               end else m_miss = 0;
               if (!a) m_mode = M_IDLE;
               else if (m_miss >= MISS_LIMIT) m_mode = M_REQ;
            end
            M_REQ: begin
               m_retry = m_retry + 1;
               m_mode = (m_retry >= MAX_RETRY) ? M_FAIL : M_IDLE;
            end
            default: ;
         endcase
      end
   endtask

   // Expected outputs: a realign request is only issued if it does not use up the last retry.
   function automatic logic [15:0] exp_vec();
      logic l, rl, f;
      l  = (m_mode == M_LOCKED);
      rl = (m_mode == M_REQ) && (m_retry + 1 < MAX_RETRY);
      f  = (m_mode == M_FAIL);
      return {l, l, rl, f, f ? 8'd0 : 8'(m_err), f ? 4'd0 : 4'(m_retry)};
   endfunction

   function automatic logic [11:0] bad_word();
      logic [11:0] w;
      if ($urandom_range(0, 1) == 1) w = PAT ^ (12'd1 << $urandom_range(0, 11));
      else begin
         w = 12'($urandom_range(0, 4095));
         if (w == PAT) w = ~PAT;
      end
      return w;
   endfunction

   // One clock: inputs applied after a falling edge, model advanced on the rising edge.
   task automatic tick(input logic a, input logic s, input logic [11:0] d);
      aligned = a; strt_pipe = s; frm_data = d;
      @(posedge clk);
      model_step(rst, a, s, d);
      @(negedge clk);
      cyc++;
      if (realign && rl_prev) rl_double++;
      rl_prev = realign;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(1'($urandom_range(0, 1)), 1'b1, bad_word());
      tick(1'b1, 1'b0, PAT);
      n_checks++;
      if (obs !== 16'h0) $display("FAIL reset_outputs cyc=%0d got=%h want=%h", cyc, obs, 16'h0);
      else n_pass++;
      rst = 1'b0;
      tick(1'b1, 1'b0, PAT);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_nominal_lock();
      int lock_at;
      int rl_seen;
      lock_at = 0; rl_seen = 0;
      tick(1'b1, 1'b1, PAT);
      for (int k = 1; k <= 26; k++) begin
         if (k > 1) tick(1'b1, 1'b0, PAT);
         if (locked && lock_at == 0) lock_at = k;
         if (realign) rl_seen++;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL nominal cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (lock_at !== 21) $display("FAIL nominal_latency got=%0d want=21", lock_at);
      else n_pass++;
      n_checks++;
      if ({rl_seen, pipe_en, err_cnt} !== {32'd0, 1'b1, 8'd0})
         $display("FAIL nominal_status realign_seen=%0d pipe_en=%b err=%0d want 0/1/0", rl_seen, pipe_en, err_cnt);
      else n_pass++;
   endtask

   task automatic test_check_mismatch();
      tick(1'b1, 1'b1, PAT);
      for (int k = 0; k < SETTLE_CYC; k++) tick(1'($urandom_range(0, 1)), 1'b0, bad_word());
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, PAT);
      tick(1'b1, 1'b0, 12'hF81);
      n_checks++;
      if ({realign, locked, retry_cnt} !== {1'b1, 1'b0, 4'd0} || obs !== exp_vec())
         $display("FAIL chk_mismatch_req cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
      tick(1'b1, 1'b0, PAT);
      n_checks++;
      if ({realign, locked, retry_cnt} !== {1'b0, 1'b0, 4'd1} || obs !== exp_vec())
         $display("FAIL chk_mismatch_idle cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
      tick(1'b1, 1'b1, PAT);
      for (int k = 0; k < SETTLE_CYC + LOCK_CNT; k++) begin
         tick(1'b1, 1'b0, PAT);
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL chk_relock cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({locked, retry_cnt} !== {1'b1, 4'd0})
         $display("FAIL chk_relock_final got locked=%b retry=%0d want 1/0", locked, retry_cnt);
      else n_pass++;
   endtask

   task automatic test_loss_of_lock();
      logic [5:0] pattern;
      pattern = 6'b111011; // bit set = mismatch, issued LSB first
      for (int k = 0; k < 6; k++) begin
         tick(1'b1, 1'b0, pattern[k] ? bad_word() : PAT);
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL lol_step cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({realign, locked, err_cnt} !== {1'b1, 1'b0, 8'd5})
         $display("FAIL lol_req got realign=%b locked=%b err=%0d want 1/0/5", realign, locked, err_cnt);
      else n_pass++;
      tick(1'b1, 1'b0, PAT);
      n_checks++;
      if ({realign, retry_cnt, err_cnt} !== {1'b0, 4'd1, 8'd5} || obs !== exp_vec())
         $display("FAIL lol_after cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_retry_exhaustion();
      int rl_total;
      rl_total = 0;
      rst = 1'b1; tick(1'b1, 1'b0, PAT); rst = 1'b0;
      for (int i = 0; i < MAX_RETRY; i++) begin
         tick(1'b1, 1'b1, PAT);
         for (int k = 0; k < SETTLE_CYC; k++) tick(1'b1, 1'b0, PAT);
         for (int k = $urandom_range(0, 4); k > 0; k--) tick(1'b1, 1'b0, PAT);
         tick(1'b1, 1'b0, bad_word());
         for (int k = 0; k < 2; k++) begin
            if (realign) rl_total++;
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL retry_step cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
            else n_pass++;
            tick(1'b1, 1'b0, PAT);
         end
      end
      n_checks++;
      if ({rl_total, align_fail} !== {32'd6, 1'b1})
         $display("FAIL retry_exhaust realigns=%0d fail=%b want 6/1", rl_total, align_fail);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, PAT);
         for (int k = 0; k < 25; k++) tick(1'b1, 1'b0, PAT);
         n_checks++;
         if ({align_fail, realign, locked, err_cnt, retry_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0, 4'd0} || obs !== exp_vec())
            $display("FAIL retry_sticky cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
         else n_pass++;
      end
      rst = 1'b1; tick(1'b1, 1'b0, PAT); rst = 1'b0;
      n_checks++;
      if (obs !== 16'h0) $display("FAIL retry_reset got=%h want=%h", obs, 16'h0);
      else n_pass++;
   endtask

   task automatic test_saturation();
      int rl_seen;
      rl_seen = 0;
      tick(1'b1, 1'b1, PAT);
      for (int k = 0; k < SETTLE_CYC + LOCK_CNT; k++) tick(1'b1, 1'b0, PAT);
      n_checks++;
      if (locked !== 1'b1) $display("FAIL sat_lock got=%b want=1", locked);
      else n_pass++;
      for (int i = 0; i < 300; i++) begin
         tick(1'b1, 1'b0, bad_word());
         if (realign) rl_seen++;
         tick(1'b1, 1'b0, PAT);
         if (realign) rl_seen++;
         if (i % 25 == 0 || i > 250) begin
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL sat_step cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
            else n_pass++;
         end
      end
      n_checks++;
      if ({err_cnt, rl_seen, locked} !== {8'd255, 32'd0, 1'b1})
         $display("FAIL sat_final err=%0d realigns=%0d locked=%b want 255/0/1", err_cnt, rl_seen, locked);
      else n_pass++;
      tick(1'b0, 1'b0, bad_word());
      n_checks++;
      if ({locked, pipe_en, realign} !== 3'b000 || obs !== exp_vec())
         $display("FAIL sat_aligned_drop cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
      else n_pass++;
      tick(1'b0, 1'b0, PAT);
      n_checks++;
      if (realign !== 1'b0) $display("FAIL sat_no_realign got=%b want=0", realign);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 1'b1, PAT);
      tick(1'b1, 1'b0, PAT);
      tick(1'b1, 1'b0, PAT);
      rst = 1'b1; tick(1'b1, 1'b0, PAT); rst = 1'b0;
      n_checks++;
      if (obs !== 16'h0) $display("FAIL rst_settle got=%h want=%h", obs, 16'h0);
      else n_pass++;
      tick(1'b1, 1'b1, PAT);
      for (int k = 0; k < SETTLE_CYC; k++) tick(1'b1, 1'b0, PAT);
      tick(1'b1, 1'b0, bad_word());
      n_checks++;
      if (realign !== 1'b1) $display("FAIL rst_req_setup got=%b want=1", realign);
      else n_pass++;
      rst = 1'b1; tick(1'b1, 1'b0, PAT); rst = 1'b0;
      n_checks++;
      if (obs !== 16'h0) $display("FAIL rst_req got=%h want=%h", obs, 16'h0);
      else n_pass++;
      tick(1'b1, 1'b0, PAT);
      n_checks++;
      if (rl_double !== 0) $display("FAIL realign_width double_cycles=%0d want 0", rl_double);
      else n_pass++;
   endtask

   task automatic test_random();
      logic a, s;
      logic [11:0] d;
      int bad_rate;
      rst = 1'b1; tick(1'b1, 1'b0, PAT); rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0) bad_rate = $urandom_range(8, 80);
         rst = ($urandom_range(0, 399) == 0);
         a = ($urandom_range(0, 149) != 0);
         s = ($urandom_range(0, 39) == 0);
         d = ($urandom_range(0, bad_rate) == 0) ? bad_word() : PAT;
         tick(a, s, d);
         rst = 1'b0;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_nominal_lock();
      test_check_mismatch();
      test_loss_of_lock();
      test_retry_exhaustion();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
